// File: rtl/commit_monitor.sv
// Retirement observer: counts cycles and retired instructions, detects the completion marker,
// then reports done after a settle window or timeout when the watchdog expires first.
module commit_monitor #(
  parameter int unsigned COMMIT_WIDTH  = 2,
  parameter logic [4:0]  MARKER_REG    = 5'd31,
  parameter logic [31:0] MARKER_VAL    = 32'hFF,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned MAX_CYCLES    = 10000,
  localparam int unsigned CntW         = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run_en,
  input  logic [COMMIT_WIDTH-1:0]   commit_we,
  input  logic [5*COMMIT_WIDTH-1:0] commit_rd,
  input  logic [32*COMMIT_WIDTH-1:0] commit_data,
  input  logic [CntW-1:0]           commit_cnt,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instret_cnt,
  output logic [1:0]                state_o,
  output logic                      done,
  output logic                      timeout
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLoad =
      SettleW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StSettle = 2'd2,
    StFinal  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         cycle_q, cycle_d, instret_q, instret_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                done_q, done_d, timeout_q, timeout_d;

  logic                hit;
  logic [31:0]         hit_data;
  logic                match;
  logic                wd_hit;
  logic [63:0]         cycle_inc, instret_inc;

  // Later slots are younger, so the last hit in the scan is the architectural winner.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_we[i] && (commit_rd[5*i +: 5] == MARKER_REG)) begin
        hit      = 1'b1;
        hit_data = commit_data[32*i +: 32];
      end
    end
    match = hit && (hit_data == MARKER_VAL) && (MARKER_REG != 5'd0);
  end

  assign cycle_inc   = cycle_q + 64'd1;
  assign instret_inc = instret_q + 64'(commit_cnt);
  assign wd_hit      = (MAX_CYCLES != 0) && (cycle_inc == 64'(MAX_CYCLES));

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    settle_d  = settle_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (run_en) state_d = StRun;
      end
      StRun: begin
        cycle_d   = cycle_inc;
        instret_d = instret_inc;
        // A match in the watchdog cycle still wins.
        if (match) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = StFinal;
            done_d  = 1'b1;
          end else begin
            state_d  = StSettle;
            settle_d = SettleLoad;
          end
        end else if (wd_hit) begin
          state_d   = StFinal;
          timeout_d = 1'b1;
        end
      end
      StSettle: begin
        cycle_d   = cycle_inc;
        instret_d = instret_inc;
        if (settle_q == '0) begin
          state_d = StFinal;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StFinal: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      instret_q <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign state_o     = state_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule
